// File: rtl/uart_recv_ctrl.sv
// uart_recv_ctrl: 8N1 UART receiver with in-order matcher for the string "hitsz2024311278"
//
// Ports:
//   clk        system clock
//   rst        asynchronous reset, active low (asserted when 0)
//   uart_rx    serial line, idle high, asynchronous to clk
//   clr        synchronous clear of match_flag and match_ptr
//   rx_data    last correctly received byte
//   rx_valid   one-cycle strobe, rx_data updated
//   frame_err  one-cycle strobe, bad stop bit (or bad parity)
//   match      one-cycle strobe, full string received (coincides with rx_valid)
//   match_flag sticky match indicator
//   match_ptr  index of the next expected character, 0..14
//
// Optional feature: define UART_RX_PARITY_EN to receive a 9th even-parity bit.
module uart_recv_ctrl #(
    parameter int CYCLES_PER_BIT = 10416,
    parameter int HALF_BIT       = CYCLES_PER_BIT / 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    input  logic       clr,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       match,
    output logic       match_flag,
    output logic [3:0] match_ptr
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    localparam logic [7:0] ROM [0:14] = '{
        8'h68, 8'h69, 8'h74, 8'h73, 8'h7A, 8'h32, 8'h30, 8'h32,
        8'h34, 8'h33, 8'h31, 8'h31, 8'h32, 8'h37, 8'h38
    };

    state_t      state, state_n;
    logic [13:0] cnt, cnt_n;
    logic [2:0]  bit_idx, bit_idx_n;
    logic [7:0]  shift, shift_n;
    logic        sync1, rx_s, rx_d;
    logic        good, bad, ok;
    logic        bit_end, half_end, fall, hit, last;
`ifdef UART_RX_PARITY_EN
    logic        par, par_n;
`endif

    assign fall     = rx_d & ~rx_s;
    assign bit_end  = cnt == 14'(CYCLES_PER_BIT - 1);
    assign half_end = cnt == 14'(HALF_BIT - 1);

    // Stop bit must be high; with parity, data plus parity bit must have even weight.
`ifdef UART_RX_PARITY_EN
    assign ok = rx_s & ~(^shift ^ par);
`else
    assign ok = rx_s;
`endif

    always_comb begin
        state_n   = state;
        cnt_n     = cnt + 14'd1;
        bit_idx_n = bit_idx;
        shift_n   = shift;
        good      = 1'b0;
        bad       = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_n     = par;
`endif
        case (state)
            IDLE: begin
                cnt_n   = '0;
                state_n = fall ? START : IDLE;
            end
            START: if (half_end) begin
                cnt_n     = '0;
                bit_idx_n = '0;
                // A line back high at mid-start was a glitch.
                state_n   = rx_s ? IDLE : DATA;
            end
            DATA: if (bit_end) begin
                cnt_n            = '0;
                shift_n[bit_idx] = rx_s;
                bit_idx_n        = (bit_idx == 3'd7) ? bit_idx : bit_idx + 3'd1;
`ifdef UART_RX_PARITY_EN
                state_n          = (bit_idx == 3'd7) ? PARITY : DATA;
`else
                state_n          = (bit_idx == 3'd7) ? STOP : DATA;
`endif
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (bit_end) begin
                cnt_n   = '0;
                par_n   = rx_s;
                state_n = STOP;
            end
`endif
            STOP: if (bit_end) begin
                // Return at mid-stop so a frame that follows immediately is caught.
                cnt_n   = '0;
                state_n = IDLE;
                good    = ok;
                bad     = ~ok;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1     <= 1'b1;
            rx_s      <= 1'b1;
            rx_d      <= 1'b1;
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par       <= 1'b0;
`endif
        end else begin
            sync1     <= uart_rx;
            rx_s      <= sync1;
            rx_d      <= rx_s;
            state     <= state_n;
            cnt       <= cnt_n;
            bit_idx   <= bit_idx_n;
            shift     <= shift_n;
            rx_valid  <= good;
            frame_err <= bad;
            if (good)
                rx_data <= shift;
`ifdef UART_RX_PARITY_EN
            par       <= par_n;
`endif
        end
    end

    assign hit   = rx_data == ROM[match_ptr];
    assign last  = match_ptr == 4'd14;
    assign match = rx_valid & hit & last;

    // On a miss an 'h' can still be the first character of a new attempt.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            match_ptr  <= '0;
            match_flag <= 1'b0;
        end else if (clr) begin
            match_ptr  <= '0;
            match_flag <= 1'b0;
        end else if (rx_valid) begin
            match_ptr  <= hit ? (last ? 4'd0 : match_ptr + 4'd1) : {3'd0, rx_data == 8'h68};
            if (match)
                match_flag <= 1'b1;
        end
    end
endmodule

// File: tb/tb_uart_recv_ctrl.sv
// tb_uart_recv_ctrl: scoreboard bench for uart_recv_ctrl with a string-matching reference model
module tb_uart_recv_ctrl;
    localparam int C = 16;
    localparam int H = C / 2;
`ifdef UART_RX_PARITY_EN
    localparam int FL = H + 10 * C + 3;
`else
    localparam int FL = H + 9 * C + 3;
`endif

    typedef struct {
        logic       err;
        logic [7:0] data;
        logic       m;
        logic [3:0] ptr;
        logic       flag;
        int         t0;
    } exp_t;

    logic       clk = 0, rst = 0, uart_rx = 1, clr = 0;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, match, match_flag;
    logic [3:0] match_ptr;

    int   n_cmp = 0, n_err = 0, cyc = 0, strobes = 0;
    exp_t q[$];
    logic [7:0] rom [0:14] = '{8'h68, 8'h69, 8'h74, 8'h73, 8'h7A, 8'h32, 8'h30, 8'h32,
                               8'h34, 8'h33, 8'h31, 8'h31, 8'h32, 8'h37, 8'h38};
    logic [7:0] m_data = 0;
    logic [3:0] m_ptr = 0;
    logic       m_flag = 0;

    uart_recv_ctrl #(.CYCLES_PER_BIT(C), .HALF_BIT(H)) dut (
        .clk(clk), .rst(rst), .uart_rx(uart_rx), .clr(clr),
        .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
        .match(match), .match_flag(match_flag), .match_ptr(match_ptr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_cmp++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, a, e);
        end
    endtask

    exp_t pe;
    logic pend = 0;
    always @(negedge clk) begin
        if (rst) begin
            if (pend) begin
                chk("pulse_width", {30'd0, rx_valid, frame_err}, 0);
                chk("match_ptr", match_ptr, pe.ptr);
                chk("match_flag", match_flag, pe.flag);
                pend = 0;
            end
            chk("exclusive", rx_valid & frame_err, 0);
            if (rx_valid | frame_err) begin
                strobes++;
                if (q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL spurious_strobe: got valid=%0b err=%0b, expected none", rx_valid, frame_err);
                end else begin
                    pe = q.pop_front();
                    chk("frame_err", frame_err, pe.err);
                    chk("rx_data", rx_data, pe.data);
                    chk("match", match, pe.m);
                    chk("latency", cyc - pe.t0, FL);
                    pend = 1;
                end
            end
        end
    end

    // Reference model: apply the string-tracking rules at frame issue time.
    task automatic send(input logic [7:0] d, input logic stop_b, input logic par_b, input int hold);
        exp_t e;
        logic good;
        good = stop_b;
`ifdef UART_RX_PARITY_EN
        good = good && (par_b == ^d);
`endif
        e.m = 0;
        if (good) begin
            m_data = d;
            if (m_ptr < 14 && d == rom[m_ptr]) m_ptr = m_ptr + 1;
            else if (m_ptr == 14 && d == rom[14]) begin
                m_ptr = 0;
                m_flag = 1;
                e.m = 1;
            end else m_ptr = (d == 8'h68) ? 1 : 0;
        end
        e.err = !good;
        e.data = m_data;
        e.ptr = m_ptr;
        e.flag = m_flag;
        e.t0 = cyc;
        q.push_back(e);
        uart_rx = 0;
        repeat (C) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = d[i];
            repeat (C) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        uart_rx = par_b;
        repeat (C) @(negedge clk);
`endif
        uart_rx = stop_b;
        repeat (C) @(negedge clk);
        if (!stop_b) begin
            repeat (hold) @(negedge clk);
            uart_rx = 1;
            repeat (4) @(negedge clk);
        end
        uart_rx = 1;
    endtask

    task automatic send_ok(input logic [7:0] d);
        send(d, 1, ^d, 0);
    endtask

    task automatic drain();
        for (int i = 0; i < 30 * C && q.size() > 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("drain_empty", q.size(), 0);
    endtask

    task automatic chk_reset();
        chk("rst_rx_data", rx_data, 0);
        chk("rst_strobes", {29'd0, rx_valid, frame_err, match}, 0);
        chk("rst_flag", match_flag, 0);
        chk("rst_ptr", match_ptr, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        int s;
        repeat (5) @(negedge clk);
        chk_reset();
        rst = 1;
        repeat (5) @(negedge clk);

        send_ok(8'h68);
        drain();

        for (int i = 0; i < 15; i++) send_ok(rom[i]);
        drain();
        chk("t2_flag", match_flag, 1);
        chk("t2_ptr", match_ptr, 0);

        send_ok(8'h68);
        for (int i = 0; i < 15; i++) send_ok(rom[i]);
        drain();
        clr = 1;
        @(negedge clk);
        clr = 0;
        m_ptr = 0;
        m_flag = 0;
        @(negedge clk);
        chk("clr_flag", match_flag, 0);
        chk("clr_ptr", match_ptr, 0);
        chk("clr_keeps_data", rx_data, m_data);

        s = strobes;
        uart_rx = 0;
        repeat (H - 4) @(negedge clk);
        uart_rx = 1;
        repeat (3 * C) @(negedge clk);
        chk("glitch_no_strobe", strobes, s);
        send_ok(8'h55);
        drain();

        s = strobes;
        send(8'hA5, 0, ^8'hA5, 3 * C);
        repeat (3 * C) @(negedge clk);
        drain();
        chk("bad_stop_one_strobe", strobes, s + 1);
        chk("bad_stop_hold", rx_data, 8'h55);

        d = 8'h3C;
        uart_rx = 0;
        repeat (C) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            uart_rx = d[i];
            repeat (C) @(negedge clk);
        end
        uart_rx = d[4];
        repeat (H) @(negedge clk);
        rst = 0;
        uart_rx = 1;
        m_data = 0;
        m_ptr = 0;
        m_flag = 0;
        repeat (3) @(negedge clk);
        chk_reset();
        rst = 1;
        repeat (5 * C) @(negedge clk);
        chk("abort_no_strobe", q.size(), 0);
        send_ok(8'h3C);
        drain();
        chk("abort_then_3c", rx_data, 8'h3C);
`ifdef UART_RX_PARITY_EN
        send(8'h3C, 1, 1, 0);
        drain();
`endif

        for (int i = 0; i < 40; i++) begin
            d = ($urandom_range(3) != 0) ? rom[m_ptr] : 8'($urandom);
            send(d, $urandom_range(7) != 0, (^d) ^ ($urandom_range(7) == 0), $urandom_range(C));
            repeat ($urandom_range(3)) @(negedge clk);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/uart_recv_ctrl.md
Name: uart_recv_ctrl

Overview:
Receive-side counterpart of the team's string-sending UART controller. It deserialises 8N1 frames arriving on uart_rx, presents each byte with a one-cycle valid strobe, and tracks the incoming byte stream against the fixed 15-character string "hitsz2024311278" (0x68 0x69 0x74 0x73 0x7A 0x32 0x30 0x32 0x34 0x33 0x31 0x31 0x32 0x37 0x38). A full, in-order match raises a match pulse and a latched flag for board LEDs. It sits at the top level beside the transmit controller and shares its clock and bit timing.

Parameters:
CYCLES_PER_BIT, 10416, clock cycles per UART bit (100 MHz / 9600 baud)
HALF_BIT, CYCLES_PER_BIT/2, cycles from the start-bit falling edge to the mid-start sample point

Ports:
clk  input  1  system clock, 100 MHz
rst  input  1  asynchronous, active-low reset (asserted when 0)
uart_rx  input  1  serial line, idle high, asynchronous to clk
clr  input  1  synchronous clear of match_flag and of the match pointer
rx_data  output  8  last correctly received byte
rx_valid  output  1  one-cycle strobe: rx_data updated
frame_err  output  1  one-cycle strobe: bad stop bit (or bad parity, see option)
match  output  1  one-cycle strobe: full string received
match_flag  output  1  sticky match indicator, cleared by clr or reset
match_ptr  output  4  index of the next expected character, 0..14

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; all counters 0; rx_data=8'h00; rx_valid, frame_err, match, match_flag=0; match_ptr=0. The synchroniser flops reset to 1 (idle line).
- uart_rx passes through a 2-flop synchroniser (rx_s). A falling-edge detect on rx_s uses a third delayed flop.
- FSM states:
  - IDLE: on a falling edge of rx_s, go to START and set cnt=0.
  - START: count to HALF_BIT-1. At that count, if rx_s=0, go to DATA with cnt=0 and bit_idx=0. Otherwise treat the edge as a glitch and return to IDLE with no strobe.
  - DATA: count to CYCLES_PER_BIT-1. At that count, sample rx_s into shift[bit_idx] (LSB first) and reset cnt. After bit_idx=7 is sampled, go to STOP; otherwise increment bit_idx.
  - STOP: at cnt=CYCLES_PER_BIT-1, sample rx_s. If it is 1, load rx_data from shift and pulse rx_valid on the next cycle. If it is 0, pulse frame_err and leave rx_data unchanged. In both cases return to IDLE immediately (at mid-stop), so back-to-back frames are accepted.
- A frame with a bad stop bit, followed by a line held low, does not re-trigger. A new start bit requires a fresh falling edge.
- Latency: rx_valid rises 2 cycles (synchroniser) plus 1 cycle (registered strobe) after the mid-stop sample.
- rx_valid and frame_err are never high in the same cycle. Each is high for exactly 1 cycle per frame.
- Match tracker, evaluated only on cycles where rx_valid=1:
  - byte == ROM[match_ptr] and match_ptr<14: match_ptr+1.
  - byte == ROM[14] and match_ptr=14: match_ptr=0, match pulses in the same cycle as rx_valid, match_flag=1.
  - Mismatch: if byte==8'h68 ('h'), match_ptr=1; else match_ptr=0.
- clr=1: match_ptr=0 and match_flag=0, with priority over a same-cycle rx_valid update. rx_data is not affected.
- Counter widths: cnt is 14 bits (it must hold CYCLES_PER_BIT-1), bit_idx is 3 bits. No wrap occurs beyond the terminal counts.
- Reset asserted mid-frame aborts the frame with no strobe. After release the FSM waits for the next falling edge.

Optional Feature:
Macro: UART_RX_PARITY_EN.
- Defined: a 9th bit (even parity) is sampled in a PARITY state between DATA and STOP, one bit time after bit 7. At the stop sample, the frame is good only if the stop bit is 1 and XOR(data, parity)=0. Otherwise frame_err pulses, rx_data is held, and the match tracker is untouched.
- Not defined: 8N1 as above, with no PARITY state.

Test Plan:
1. Reset, then send byte 0x68 at 10416 cycles/bit → rx_data=8'h68; rx_valid one cycle high, 3 cycles after the mid-stop sample; match_ptr=1.
2. Send "hitsz2024311278" back-to-back with no idle gap → 15 rx_valid pulses; match pulses once with the 15th; match_flag=1; match_ptr=0.
3. Send "hhitsz2024311278" → after the second 'h', match_ptr=1; a full match still occurs at the end; then clr=1 for one cycle → match_flag=0.
4. Pull uart_rx low for 3000 cycles, then high → no strobe; FSM back in IDLE; the next valid frame 0x55 is received correctly.
5. Send 0xA5 with stop bit 0 → frame_err pulses for 1 cycle; rx_valid stays 0; rx_data keeps its previous value.
6. Assert rst=0 during data bit 4 of a frame, release, then send 0x3C → no strobe for the aborted frame; rx_data=8'h3C afterwards. With UART_RX_PARITY_EN, sending 0x3C with parity 1 → frame_err.
